// File: rtl/mbist_march_engine.sv
// March C- memory BIST engine with functional pass-through.
// Runs NBG data backgrounds of March C- (E0..E5) over a WCOUNT x WLENGTH
// memory. Read data is checked RD_LAT cycles after each read is issued.
// Optional macro MBIST_FAIL_LOG_EN keeps a first-failure log
// (address, expected, actual, element); without it fail_* read as 0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           single-cycle test request (honoured in IDLE/DONE)
//   func_*          functional memory request, forwarded when not testing
//   mem_*           memory request to the array; mem_rdata read return
//   busy/done/fail  status; done and fail are sticky until next start
//   fail_*          first-failure log
module mbist_march_engine #(
  parameter int unsigned WCOUNT  = 256,
  parameter int unsigned WLENGTH = 4,
  parameter int unsigned NBG     = 3,
  parameter int unsigned RD_LAT  = 1,
  localparam int unsigned AW     = $clog2(WCOUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               func_we,
  input  logic [AW-1:0]      func_addr,
  input  logic [WLENGTH-1:0] func_wdata,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [WLENGTH-1:0] mem_wdata,
  input  logic [WLENGTH-1:0] mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [AW-1:0]      fail_addr,
  output logic [WLENGTH-1:0] fail_exp,
  output logic [WLENGTH-1:0] fail_act,
  output logic [2:0]         fail_elem
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [1:0]         bg_q, bg_d;
  logic [2:0]         elem_q, elem_d;
  logic               op_q, op_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [2:0]         drain_q, drain_d;
  logic               start_acc;
  logic               fail_q;

  logic               is_down, single_op, eng_we, run_we, data_one, last_op, last_idx;
  logic               issue_rd, eng_sel, mismatch;
  logic [AW-1:0]      eng_addr;
  logic [WLENGTH-1:0] bg_word, eng_data;

  logic [RD_LAT-1:0]  pv_q;
  logic [WLENGTH-1:0] pexp_q [RD_LAT];

  // Data background: BG0 zeros, BG1 bit i = i[0], BG2 bit i = i[1]
  always_comb begin
    bg_word = '0;
    for (int i = 0; i < int'(WLENGTH); i++) begin
      case (bg_q)
        2'd1:    bg_word[i] = i[0];
        2'd2:    bg_word[i] = i[1];
        default: bg_word[i] = 1'b0;
      endcase
    end
  end

  // Operation decode: op 0 is the read (or the only op), op 1 the write
  assign is_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign single_op = (elem_q == 3'd0) || (elem_q == 3'd5);
  assign eng_we    = (elem_q == 3'd0) || op_q;
  assign data_one  = op_q ? ((elem_q == 3'd1) || (elem_q == 3'd3))
                          : ((elem_q == 3'd2) || (elem_q == 3'd4));
  // Depth is a power of two, so ~idx walks WCOUNT-1 down to 0
  assign eng_addr  = is_down ? ~idx_q : idx_q;
  assign eng_data  = data_one ? ~bg_word : bg_word;
  assign last_op   = single_op || op_q;
  assign last_idx  = (idx_q == AW'(WCOUNT - 1));
  assign run_we    = (state_q == RUN) && eng_we;
  assign issue_rd  = (state_q == RUN) && !eng_we;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bg_q    <= '0;
      elem_q  <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
    end
  end

  // Next state and march sequencing
  always_comb begin
    state_d   = state_q;
    bg_d      = bg_q;
    elem_d    = elem_q;
    op_d      = op_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          bg_d      = '0;
          elem_d    = '0;
          op_d      = 1'b0;
          idx_d     = '0;
          start_acc = 1'b1;
        end
      end
      RUN: begin
        if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d  = 1'b0;
          idx_d = idx_q + AW'(1);
          if (last_idx) begin
            if (elem_q == 3'd5) begin
              elem_d = '0;
              if (bg_q == 2'(NBG - 1)) begin
                state_d = DRAIN;
                drain_d = '0;
              end else begin
                bg_d = bg_q + 2'd1;
              end
            end else begin
              elem_d = elem_q + 3'd1;
            end
          end
        end
      end
      DRAIN: begin
        if (drain_q == 3'(RD_LAT - 1)) state_d = DONE;
        else                           drain_d = drain_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Compare at the tail of the read pipeline
  assign mismatch = pv_q[RD_LAT-1] && (mem_rdata != pexp_q[RD_LAT-1]);

  // Read-valid pipeline and sticky fail
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q   <= '0;
      fail_q <= 1'b0;
    end else if (start_acc) begin
      pv_q   <= '0;
      fail_q <= 1'b0;
    end else begin
      pv_q <= (pv_q << 1) | RD_LAT'(issue_rd);
      if (mismatch) fail_q <= 1'b1;
    end
  end

  // Expected-data pipeline; qualified by pv_q so no reset needed
  always_ff @(posedge clk) begin
    pexp_q[0] <= eng_data;
    for (int s = 1; s < int'(RD_LAT); s++) pexp_q[s] <= pexp_q[s-1];
  end

`ifdef MBIST_FAIL_LOG_EN
  logic [AW-1:0]      paddr_q [RD_LAT];
  logic [2:0]         pelem_q [RD_LAT];
  logic [AW-1:0]      log_addr_q;
  logic [WLENGTH-1:0] log_exp_q, log_act_q;
  logic [2:0]         log_elem_q;

  // Address/element ride alongside the expected data
  always_ff @(posedge clk) begin
    paddr_q[0] <= eng_addr;
    pelem_q[0] <= elem_q;
    for (int s = 1; s < int'(RD_LAT); s++) begin
      paddr_q[s] <= paddr_q[s-1];
      pelem_q[s] <= pelem_q[s-1];
    end
  end

  // First-failure capture; later mismatches leave it alone
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      log_addr_q <= '0;
      log_exp_q  <= '0;
      log_act_q  <= '0;
      log_elem_q <= '0;
    end else if (mismatch && !fail_q) begin
      log_addr_q <= paddr_q[RD_LAT-1];
      log_exp_q  <= pexp_q[RD_LAT-1];
      log_act_q  <= mem_rdata;
      log_elem_q <= pelem_q[RD_LAT-1];
    end
  end

  assign fail_addr = log_addr_q;
  assign fail_exp  = log_exp_q;
  assign fail_act  = log_act_q;
  assign fail_elem = log_elem_q;
`else
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
  assign fail_elem = '0;
`endif

  // Status and memory port mux; reset always hands the port back
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign fail      = fail_q;
  assign eng_sel   = busy && !rst;
  assign mem_we    = eng_sel ? run_we   : func_we;
  assign mem_addr  = eng_sel ? eng_addr : func_addr;
  assign mem_wdata = eng_sel ? eng_data : func_wdata;

endmodule

// File: tb/tb_mbist_march_engine.sv
// Bench for mbist_march_engine: WCOUNT=16, WLENGTH=4, NBG=3.
// u0 uses RD_LAT=1, u1 uses RD_LAT=3; each has its own RAM model with
// fault hooks (stuck bit, single corrupted read).
module tb_mbist_march_engine;

`ifdef MBIST_FAIL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s0, s1, fwe;
  logic [3:0] faddr, fwdata;

  logic       m0_we, b0, d0, f0;
  logic [3:0] m0_addr, m0_wdata, m0_rdata, fa0, fx0, fy0;
  logic [2:0] fl0;
  logic       m1_we, b1, d1, f1;
  logic [3:0] m1_addr, m1_wdata, m1_rdata, fa1, fx1, fy1;
  logic [2:0] fl1;

  mbist_march_engine #(.WCOUNT(16), .WLENGTH(4), .NBG(3), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .start(s0), .func_we(fwe), .func_addr(faddr),
    .func_wdata(fwdata), .mem_we(m0_we), .mem_addr(m0_addr), .mem_wdata(m0_wdata),
    .mem_rdata(m0_rdata), .busy(b0), .done(d0), .fail(f0), .fail_addr(fa0),
    .fail_exp(fx0), .fail_act(fy0), .fail_elem(fl0));

  mbist_march_engine #(.WCOUNT(16), .WLENGTH(4), .NBG(3), .RD_LAT(3)) u1 (
    .clk(clk), .rst(rst), .start(s1), .func_we(fwe), .func_addr(faddr),
    .func_wdata(fwdata), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(b1), .done(d1), .fail(f1), .fail_addr(fa1),
    .fail_exp(fx1), .fail_act(fy1), .fail_elem(fl1));

  // RAM for u0: 1-cycle read, optional stuck-at-1 on bit 0 of word 5,
  // optional single flip of the read issued at run cycle 100
  logic [3:0] mem0 [16];
  logic [3:0] rd0;
  logic       stuck5, inj100;
  int         cyc;
  always @(posedge clk) begin
    if (m0_we) mem0[m0_addr] <= m0_wdata;
    rd0 <= (mem0[m0_addr] | ((stuck5 && m0_addr == 4'd5) ? 4'h1 : 4'h0))
         ^ ((inj100 && cyc == 100 && !m0_we) ? 4'h1 : 4'h0);
  end
  assign m0_rdata = rd0;

  // RAM for u1: 3-cycle read, optional flip of the 15th test read of word 15
  logic [3:0] mem1 [16];
  logic [3:0] rp1 [3];
  logic       inj_last, clr15;
  int         r15;
  always @(posedge clk) begin
    if (m1_we) mem1[m1_addr] <= m1_wdata;
    if (clr15) r15 <= 0;
    else if (b1 && !m1_we && m1_addr == 4'd15) r15 <= r15 + 1;
    rp1[0] <= mem1[m1_addr]
            ^ ((inj_last && b1 && !m1_we && m1_addr == 4'd15 && r15 == 14) ? 4'h1 : 4'h0);
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign m1_rdata = rp1[2];

  int total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [3:0] wd;
    logic       e_we;
    logic [3:0] e_addr;
    logic [3:0] e_wd;
  } pt_t;

  typedef struct {
    int         c;
    logic       we;
    logic [3:0] addr;
    logic [3:0] wd;
    logic       cwd;
  } ev_t;

  pt_t pt [4];
  ev_t ev [20];

  // mode 0: ideal RAM + op table + ignored start; 1: stuck fault; 2: reset mid-run
  task automatic run0(input int mode, output int n);
    int c;
    s0 = 1'b1;
    tick;
    s0 = 1'b0;
    c = 0;
    cyc = 0;
    if (mode != 0) begin
      chk("start_clears_fail", 32'(f0), 0);
      chk("start_clears_done", 32'(d0), 0);
      chk("start_clears_log", 32'(fa0), 0);
    end
    while (b0 && c < 2000) begin
      if (mode == 0) begin
        for (int k = 0; k < 20; k++) begin
          if (ev[k].c == c) begin
            chk($sformatf("op%0d_we", c), 32'(m0_we), 32'(ev[k].we));
            chk($sformatf("op%0d_addr", c), 32'(m0_addr), 32'(ev[k].addr));
            if (ev[k].cwd) chk($sformatf("op%0d_wdata", c), 32'(m0_wdata), 32'(ev[k].wd));
          end
        end
        if (c == 50) s0 = 1'b1;
      end
      if (mode == 1 && c == 27) chk("fail_low_during_compare", 32'(f0), 0);
      if (mode == 1 && c == 28) chk("fail_after_edge", 32'(f0), 1);
      if (mode == 2 && c == 101) begin
        // read issued at cycle 100 is still on its way back
        rst = 1'b1;
        faddr = 4'd9;
        fwdata = 4'h6;
        fwe = 1'b0;
        #1;
        chk("rst_pass_we", 32'(m0_we), 0);
        chk("rst_pass_addr", 32'(m0_addr), 9);
        chk("rst_pass_wdata", 32'(m0_wdata), 32'h6);
      end
      tick;
      s0 = 1'b0;
      rst = 1'b0;
      c++;
      cyc = c;
    end
    n = c;
  endtask

  initial begin
    int n, c;
    logic fb;
    total = 0; bad = 0;
    rst = 1'b1; s0 = 1'b0; s1 = 1'b0; fwe = 1'b0; faddr = '0; fwdata = '0;
    stuck5 = 1'b0; inj100 = 1'b0; inj_last = 1'b0; clr15 = 1'b1; cyc = 0;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end

    pt[0] = '{1'b1, 4'd3,  4'hA, 1'b1, 4'd3,  4'hA};
    pt[1] = '{1'b0, 4'd15, 4'h5, 1'b0, 4'd15, 4'h5};
    pt[2] = '{1'b1, 4'd0,  4'hF, 1'b1, 4'd0,  4'hF};
    pt[3] = '{1'b0, 4'd9,  4'h0, 1'b0, 4'd9,  4'h0};

    // March C- schedule for 16 words: E0 0-15, E1 16-47, E2 48-79,
    // E3 80-111, E4 112-143, E5 144-159; backgrounds every 160 cycles
    ev[0]  = '{0,   1'b1, 4'd0,  4'h0, 1'b1};
    ev[1]  = '{15,  1'b1, 4'd15, 4'h0, 1'b1};
    ev[2]  = '{16,  1'b0, 4'd0,  4'h0, 1'b0};
    ev[3]  = '{17,  1'b1, 4'd0,  4'hF, 1'b1};
    ev[4]  = '{48,  1'b0, 4'd0,  4'h0, 1'b0};
    ev[5]  = '{49,  1'b1, 4'd0,  4'h0, 1'b1};
    ev[6]  = '{51,  1'b1, 4'd1,  4'h0, 1'b1};
    ev[7]  = '{80,  1'b0, 4'd15, 4'h0, 1'b0};
    ev[8]  = '{81,  1'b1, 4'd15, 4'hF, 1'b1};
    ev[9]  = '{113, 1'b1, 4'd15, 4'h0, 1'b1};
    ev[10] = '{144, 1'b0, 4'd0,  4'h0, 1'b0};
    ev[11] = '{159, 1'b0, 4'd15, 4'h0, 1'b0};
    ev[12] = '{160, 1'b1, 4'd0,  4'hA, 1'b1};
    ev[13] = '{177, 1'b1, 4'd0,  4'h5, 1'b1};
    ev[14] = '{209, 1'b1, 4'd0,  4'hA, 1'b1};
    ev[15] = '{241, 1'b1, 4'd15, 4'h5, 1'b1};
    ev[16] = '{320, 1'b1, 4'd0,  4'hC, 1'b1};
    ev[17] = '{337, 1'b1, 4'd0,  4'h3, 1'b1};
    ev[18] = '{401, 1'b1, 4'd15, 4'h3, 1'b1};
    ev[19] = '{479, 1'b0, 4'd15, 4'h0, 1'b0};

    tick;
    tick;
    fwe = 1'b1; faddr = 4'd7; fwdata = 4'h5;
    #1;
    chk("inrst_pass_we", 32'(m0_we), 1);
    chk("inrst_pass_addr", 32'(m0_addr), 7);
    chk("inrst_pass_wdata", 32'(m0_wdata), 32'h5);
    tick;
    rst = 1'b0; clr15 = 1'b0; fwe = 1'b0;

    chk("reset_busy", 32'(b0), 0);
    chk("reset_done", 32'(d0), 0);
    chk("reset_fail", 32'(f0), 0);
    chk("reset_log_addr", 32'(fa0), 0);
    chk("reset_u1_busy", 32'(b1), 0);

    // Functional pass-through in IDLE
    for (int k = 0; k < 4; k++) begin
      fwe = pt[k].we; faddr = pt[k].addr; fwdata = pt[k].wd;
      #1;
      chk($sformatf("pass%0d_we", k), 32'(m0_we), 32'(pt[k].e_we));
      chk($sformatf("pass%0d_addr", k), 32'(m0_addr), 32'(pt[k].e_addr));
      chk($sformatf("pass%0d_wdata", k), 32'(m0_wdata), 32'(pt[k].e_wd));
      chk($sformatf("pass%0d_u1_addr", k), 32'(m1_addr), 32'(pt[k].e_addr));
    end
    fwe = 1'b0; faddr = '0; fwdata = '0;
    tick;

    // Ideal RAM, start re-pulsed at cycle 50
    run0(0, n);
    chk("ideal_busy_cycles", n, 481);
    chk("ideal_done", 32'(d0), 1);
    chk("ideal_fail", 32'(f0), 0);
    tick;
    chk("done_sticky", 32'(d0), 1);

    // Stuck-at-1 on bit 0 of word 5
    stuck5 = 1'b1;
    run0(1, n);
    chk("stuck_busy_cycles", n, 481);
    chk("stuck_done", 32'(d0), 1);
    chk("stuck_fail", 32'(f0), 1);
    chk("stuck_log_addr", 32'(fa0), LOG ? 32'd5 : 32'd0);
    chk("stuck_log_elem", 32'(fl0), LOG ? 32'd1 : 32'd0);
    chk("stuck_log_exp", 32'(fx0), 32'd0);
    chk("stuck_log_act", 32'(fy0), LOG ? 32'd1 : 32'd0);
    stuck5 = 1'b0;

    // Reset while a corrupted read is in flight
    inj100 = 1'b1;
    run0(2, n);
    inj100 = 1'b0;
    chk("rst_exit_cycle", n, 102);
    chk("rst_busy", 32'(b0), 0);
    chk("rst_done", 32'(d0), 0);
    chk("rst_fail", 32'(f0), 0);
    fwe = 1'b1; faddr = 4'd3; fwdata = 4'hA;
    #1;
    chk("post_rst_pass_we", 32'(m0_we), 1);
    chk("post_rst_pass_addr", 32'(m0_addr), 3);
    chk("post_rst_pass_wdata", 32'(m0_wdata), 32'hA);
    fwe = 1'b0;
    tick;
    tick;
    chk("post_rst_fail_quiet", 32'(f0), 0);
    chk("post_rst_idle", 32'(b0), 0);

    // RD_LAT=3, only the very last E5 read of word 15 is corrupted
    inj_last = 1'b1;
    clr15 = 1'b1;
    tick;
    clr15 = 1'b0;
    s1 = 1'b1;
    tick;
    s1 = 1'b0;
    c = 0;
    fb = 1'b1;
    while (b1 && c < 2000) begin
      fb = f1;
      tick;
      c++;
    end
    chk("lat3_busy_cycles", c, 483);
    chk("lat3_fail_before_done", 32'(fb), 0);
    chk("lat3_done", 32'(d1), 1);
    chk("lat3_fail", 32'(f1), 1);
    chk("lat3_log_addr", 32'(fa1), LOG ? 32'd15 : 32'd0);
    chk("lat3_log_elem", 32'(fl1), LOG ? 32'd5 : 32'd0);
    chk("lat3_log_exp", 32'(fx1), LOG ? 32'hC : 32'd0);
    chk("lat3_log_act", 32'(fy1), LOG ? 32'hD : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
